// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state encoding and the bit-counter width helper.
// Imported by seq_multiplier; contains no logic.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit over clog2 so the counter can reach WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/nbit_adder.sv
// Parametrised ripple-carry adder used for each shift-add step.
// Latency: purely combinational.
// Backpressure: none; no flow control.
module nbit_adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar g = 0; g < N; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[N];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: out_valid rises WIDTH clock edges after the acceptance edge.
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE.
// Optional macro SEQ_MULT_SIGNED_EN adds op_signed for two's-complement operands.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         r_state;
  state_t         w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;

  logic           w_signed;
  logic           w_bit;
  logic           w_sub;
  logic [WIDTH:0] w_acc;
  logic [WIDTH:0] w_mcand;
  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;
  logic           w_cin;
  logic           w_unused_cout;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_signed;

  // Operand signedness is sampled only on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_signed <= op_signed;
    end
  end

  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  // The extra adder bit is a sign extension in signed mode and holds the
  // WIDTH-bit carry-out in unsigned mode, so it becomes the accumulator MSB.
  assign w_bit    = r_lo[0];
  assign w_sub    = w_signed & (r_cnt == LAST);
  assign w_acc    = {w_signed & r_hi[WIDTH-1], r_hi};
  assign w_mcand  = {w_signed & r_a[WIDTH-1], r_a};
  assign w_addend = !w_bit ? '0 : (w_sub ? ~w_mcand : w_mcand);
  assign w_cin    = w_bit & w_sub;

  nbit_adder #(.N(WIDTH + 1)) u_adder (
    .i_a    (w_acc),
    .i_b    (w_addend),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture operands on acceptance, then add-and-shift once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a   <= a;
      r_hi  <= '0;
      r_lo  <= b;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign p = {r_hi, r_lo};

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4.
// Expected products are queued at stimulus time and popped when out_valid rises.
// Signed-mode scenarios are built only when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SEQ_MULT_SIGNED_EN
  logic             op_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [2*WIDTH-1:0] p;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed (op_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // Present operands for one acceptance edge, queue the expected product,
  // then scramble the inputs so later changes cannot leak into the result.
  task automatic accept(input logic [3:0] ia, input logic [3:0] ib,
                        input logic sg, input logic [7:0] expv);
    a        = ia;
    b        = ib;
`ifdef SEQ_MULT_SIGNED_EN
    op_signed = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
    op_signed = 1'($urandom);
`endif
  endtask

  // Count edges after acceptance until out_valid; lat=-1 if it never comes.
  task automatic wait_out(output int lat, output int rdy_seen);
    lat      = -1;
    rdy_seen = (in_ready !== 1'b0) ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (in_ready !== 1'b0) rdy_seen++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SEQ_MULT_SIGNED_EN
    op_signed = 1'b0;
`endif
    #12;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (p !== 8'h00) begin failures++; $display("FAIL reset_p got=%h want=00", p); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max();
    int lat, rdy;
    logic [7:0] e;
    out_ready = 1'b1;
    accept(4'hF, 4'hF, 1'b0, 8'hE1);
    wait_out(lat, rdy);
    e = exp_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin failures++; $display("FAIL max_latency got=%0d want=%0d", lat, WIDTH); end
    checks++;
    if (rdy !== 0) begin failures++; $display("FAIL max_in_ready_low got=%0d cycles high want=0", rdy); end
    checks++;
    if (p !== e) begin failures++; $display("FAIL max_product got=%h want=%h", p, e); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL max_return_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rdy;
    logic [7:0] e;
    out_ready = 1'b1;
    accept(4'h0, 4'hB, 1'b0, 8'h00);
    // Second request is held asserted for the whole first operation.
    a        = 4'h9;
    b        = 4'h1;
    in_valid = 1'b1;
    exp_q.push_back(8'h09);
    wait_out(lat, rdy);
    e = exp_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, WIDTH); end
    checks++;
    if (p !== e) begin failures++; $display("FAIL b2b_first_product got=%h want=%h", p, e); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_no_accept_on_handshake in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept busy=%b want=1", busy); end
    wait_out(lat, rdy);
    e = exp_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin failures++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, WIDTH); end
    checks++;
    if (p !== e) begin failures++; $display("FAIL b2b_second_product got=%h want=%h", p, e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat, rdy, bad;
    logic [7:0] e;
    out_ready = 1'b0;
    accept(4'h7, 4'h6, 1'b0, 8'h2A);
    wait_out(lat, rdy);
    e = exp_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, WIDTH); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (p !== e || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d unstable cycles (last p=%h ov=%b) want=0 p=%h", bad, p, out_valid, e); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, rdy;
    logic [7:0] e;
    out_ready = 1'b1;
    accept(4'hD, 4'hE, 1'b0, 8'hB6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (p !== 8'h00) begin failures++; $display("FAIL rst_run_p got=%h want=00", p); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_run_flags ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept(4'h3, 4'h5, 1'b0, 8'h0F);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_first_accept busy=%b want=1", busy); end
    wait_out(lat, rdy);
    e = exp_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin failures++; $display("FAIL rst_after_latency got=%0d want=%0d", lat, WIDTH); end
    checks++;
    if (p !== e) begin failures++; $display("FAIL rst_after_product got=%h want=%h", p, e); end
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    int lat, rdy;
    logic [7:0] e;
    logic [3:0] va[3] = '{4'h8, 4'hF, 4'hF};
    logic [3:0] vb[3] = '{4'h8, 4'h7, 4'h7};
    logic       vs[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] ve[3] = '{8'h40, 8'hF9, 8'h69};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i], vs[i], ve[i]);
      wait_out(lat, rdy);
      e = exp_q.pop_front();
      checks++;
      if (lat !== WIDTH) begin failures++; $display("FAIL signed_latency[%0d] got=%0d want=%0d", i, lat, WIDTH); end
      checks++;
      if (p !== e) begin failures++; $display("FAIL signed_product[%0d] got=%h want=%h", i, p, e); end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
